// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and state type for the TPU SRAM address path
//
// Holds the serial number width, SRAM address width, the default final
// serial number and the address sequencer state enumeration.
package tpu_pkg;

  localparam int ADDR_SERIAL_NUM_WIDTH = 7;
  localparam int SRAM_ADDR_WIDTH       = 10;
  localparam int LAST_NUM              = 126;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/addr_serial_seq.sv
// rtl/addr_serial_seq.sv - serial number sequencer feeding addr_sel
//
// Issues serial numbers 0..LAST_NUM, one per unstalled cycle, then waits
// DRAIN_CYCLES for SRAM read data to settle and pulses done for one cycle.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           begin a sequence (ignored while busy)
//   stall           hold the current serial number
//   abort           terminate the sequence at once, no done pulse
//   addr_serial_num serial number driven straight to addr_sel
//   valid           addr_serial_num is issued this cycle
//   busy            sequence in progress (RUN or DRAIN)
//   done            one-cycle completion pulse
module addr_serial_seq #(
  parameter int ADDR_SERIAL_NUM_WIDTH = tpu_pkg::ADDR_SERIAL_NUM_WIDTH,
  parameter int LAST_NUM              = tpu_pkg::LAST_NUM,
  parameter int DRAIN_CYCLES          = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             stall,
  input  logic                             abort,
  output logic [ADDR_SERIAL_NUM_WIDTH-1:0] addr_serial_num,
  output logic                             valid,
  output logic                             busy,
  output logic                             done
);

  import tpu_pkg::*;

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [ADDR_SERIAL_NUM_WIDTH-1:0] NUM_LAST   = ADDR_SERIAL_NUM_WIDTH'(LAST_NUM);
  localparam logic [ADDR_SERIAL_NUM_WIDTH-1:0] NUM_ONE    = ADDR_SERIAL_NUM_WIDTH'(1);
  localparam logic [DRAIN_W-1:0]               DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0]               DRAIN_ONE  = DRAIN_W'(1);

  seq_state_e         state;
  logic [DRAIN_W-1:0] drain_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_serial_num <= '0;
      drain_cnt       <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Also covers the done cycle, so back-to-back runs have no gap.
          if (start && !abort) begin
            state           <= RUN;
            addr_serial_num <= '0;
          end
        end
        RUN: begin
          // abort outranks stall; start is never looked at once busy.
          if (abort) begin
            state           <= IDLE;
            addr_serial_num <= '0;
          end else if (!stall) begin
            if (addr_serial_num == NUM_LAST) begin
              // Hold the last number so it never wraps past LAST_NUM.
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
            end else begin
              addr_serial_num <= addr_serial_num + NUM_ONE;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state           <= IDLE;
            addr_serial_num <= '0;
          end else if (drain_cnt == '0) begin
            state           <= IDLE;
            addr_serial_num <= '0;
            done            <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        default: begin
          state           <= IDLE;
          addr_serial_num <= '0;
        end
      endcase
    end
  end

  // valid drops in the same cycle stall rises so downstream never sees a repeat.
  assign valid = (state == RUN) && !stall;
  assign busy  = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_addr_serial_seq.sv
// tb/tb_addr_serial_seq.sv - scoreboard bench for addr_serial_seq
module tb_addr_serial_seq;

  localparam int W     = 7;
  localparam int LAST  = 126;
  localparam int DRAIN = 2;

  logic         clk = 1'b0;
  logic         rst_n, start, stall, abort;
  logic [W-1:0] addr_serial_num;
  logic         valid, busy, done;

  addr_serial_seq #(
    .ADDR_SERIAL_NUM_WIDTH(W),
    .LAST_NUM             (LAST),
    .DRAIN_CYCLES         (DRAIN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stall          (stall),
    .abort          (abort),
    .addr_serial_num(addr_serial_num),
    .valid          (valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: a run is "how many numbers issued so far" plus the
  // cycle the last number went out; done lands DRAIN+1 cycles after that.
  int  exp_num_q[$];
  int  exp_done_q[$];
  int  done_cycles[$];
  bit  exp_valid = 1'b0, exp_busy = 1'b0;
  bit  m_run = 1'b0;
  int  m_issued = 0, m_clast = -1;
  bit  prev_busy = 1'b0, prev_start = 1'b0, prev_abort = 1'b0;
  bit  mon_en = 1'b0;
  int  n_checks = 0, n_fail = 0;
  int  n_valid_seen = 0, n_busy_seen = 0;
  bit  b2b_used = 1'b0;
  int  stall_left = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: did not complete within cycle budget (cycle %0d)", name, edge_cnt);
  endtask

  always @(negedge clk) begin
    bit exp_d;
    if (mon_en) begin
      chk("valid", int'(valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_busy));
      if (valid) begin
        n_valid_seen++;
        if (exp_num_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL num: unexpected issue of %0d, expected none (cycle %0d)", addr_serial_num, edge_cnt);
        end else begin
          chk("num", int'(addr_serial_num), exp_num_q.pop_front());
        end
      end
      if (busy) n_busy_seen++;
      exp_d = (exp_done_q.size() != 0) && (exp_done_q[0] == edge_cnt);
      if (exp_d) void'(exp_done_q.pop_front());
      chk("done", int'(done), int'(exp_d));
      if (done) done_cycles.push_back(edge_cnt);
    end
  end

  // Apply the effect of last cycle's inputs at the edge just taken.
  task automatic cycle_begin();
    @(posedge clk);
    #1;
    if (prev_busy && prev_abort) begin
      m_run = 1'b0;
      chk("num_q_empty_at_abort", exp_num_q.size(), 0);
      exp_num_q.delete();
      while (exp_done_q.size() != 0 && exp_done_q[$] >= edge_cnt) void'(exp_done_q.pop_back());
    end else if (!prev_busy && prev_start && !prev_abort) begin
      m_run    = 1'b1;
      m_issued = 0;
      m_clast  = -1;
    end
    if (m_run && m_clast >= 0 && edge_cnt > m_clast + DRAIN) m_run = 1'b0;
    exp_busy = m_run;
  endtask

  // Inputs for this cycle are set; record what should be issued now.
  task automatic cycle_end();
    exp_valid = m_run && (m_clast < 0) && !stall;
    if (exp_valid) begin
      exp_num_q.push_back(m_issued);
      m_issued++;
      if (m_issued == LAST + 1) begin
        m_clast = edge_cnt;
        exp_done_q.push_back(edge_cnt + DRAIN + 1);
      end
    end
    prev_busy  = exp_busy;
    prev_start = start;
    prev_abort = abort;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_begin();
      start = 1'b0; stall = 1'b0; abort = 1'b0;
      cycle_end();
    end
  endtask

  task automatic start_pulse(output int e0);
    done_cycles.delete();
    n_valid_seen = 0;
    n_busy_seen  = 0;
    cycle_begin();
    start = 1'b1; stall = 1'b0; abort = 1'b0;
    cycle_end();
    e0 = edge_cnt + 1;
  endtask

  // mode 0 plain, 1 stall at 31, 2 abort at 62, 3 start while busy,
  // 4 back-to-back restart in done cycle, 5 random stall/start/abort.
  task automatic run_policy(input int mode, input string tag);
    int n = 0;
    stall_left = 5;
    b2b_used   = 1'b0;
    do begin
      cycle_begin();
      start = 1'b0; stall = 1'b0; abort = 1'b0;
      case (mode)
        1: begin
          stall = m_run && m_clast < 0 && m_issued == 31 && stall_left > 0;
          if (stall) stall_left--;
        end
        2: abort = m_run && m_clast < 0 && m_issued == 62;
        3: start = m_run && ((m_clast < 0 && m_issued == 10) || (m_clast >= 0 && edge_cnt == m_clast + 1));
        4: begin
          start = !b2b_used && !m_run && exp_done_q.size() != 0 && exp_done_q[0] == edge_cnt;
          if (start) b2b_used = 1'b1;
        end
        5: begin
          stall = ($urandom_range(0, 3) == 0);
          start = m_run && ($urandom_range(0, 15) == 0);
          abort = m_run && ($urandom_range(0, 299) == 0);
        end
        default: ;
      endcase
      cycle_end();
      n++;
    end while ((m_run || exp_done_q.size() != 0) && n < 1000);
    if (n >= 1000) bound_fail(tag);
  endtask

  initial begin
    int e0;
    int n;
    rst_n = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_num", int'(addr_serial_num), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle_cycles(2);

    // Nominal run.
    start_pulse(e0);
    run_policy(0, "nominal");
    chk("nominal_done_count", done_cycles.size(), 1);
    chk("nominal_done_latency", (done_cycles.size() == 1) ? done_cycles[0] - e0 : -1, 129);
    chk("nominal_valid_cycles", n_valid_seen, 127);
    chk("nominal_busy_cycles", n_busy_seen, 129);
    idle_cycles(3);

    // Five-cycle stall at 31.
    start_pulse(e0);
    run_policy(1, "stall");
    chk("stall_done_latency", (done_cycles.size() == 1) ? done_cycles[0] - e0 : -1, 134);
    chk("stall_valid_cycles", n_valid_seen, 127);
    idle_cycles(2);

    // Abort at 62, then a full run.
    start_pulse(e0);
    run_policy(2, "abort");
    chk("abort_num_zero", int'(addr_serial_num), 0);
    chk("abort_busy_low", int'(busy), 0);
    idle_cycles(140);
    chk("abort_no_done", done_cycles.size(), 0);
    start_pulse(e0);
    run_policy(0, "after_abort");
    chk("after_abort_done_latency", (done_cycles.size() == 1) ? done_cycles[0] - e0 : -1, 129);
    idle_cycles(2);

    // Reset asserted while 98 is on the bus.
    start_pulse(e0);
    n = 0;
    forever begin
      cycle_begin();
      if (m_issued == 98 || n >= 300) break;
      start = 1'b0; stall = 1'b0; abort = 1'b0;
      cycle_end();
      n++;
    end
    if (n >= 300) bound_fail("reset_reach_98");
    chk("pre_reset_num", int'(addr_serial_num), 98);
    rst_n = 1'b0;
    #1;
    chk("midreset_num", int'(addr_serial_num), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    m_run = 1'b0;
    exp_busy = 1'b0;
    exp_done_q.delete();
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    cycle_end();
    idle_cycles(2);
    cycle_begin();
    rst_n = 1'b1;
    cycle_end();
    idle_cycles(140);
    chk("reset_no_done", done_cycles.size(), 0);

    // Start pulses while busy are ignored.
    start_pulse(e0);
    run_policy(3, "start_busy");
    chk("start_busy_done_count", done_cycles.size(), 1);
    chk("start_busy_done_latency", (done_cycles.size() == 1) ? done_cycles[0] - e0 : -1, 129);
    idle_cycles(2);

    // Back-to-back: restart in the done cycle.
    start_pulse(e0);
    run_policy(4, "b2b");
    chk("b2b_done_count", done_cycles.size(), 2);
    chk("b2b_done_gap", (done_cycles.size() == 2) ? done_cycles[1] - done_cycles[0] : -1, 130);
    idle_cycles(2);

    // Randomized runs with idle noise (including start+abort together).
    for (int r = 0; r < 6; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        cycle_begin();
        start = ($urandom_range(0, 1) == 1);
        abort = start;
        stall = ($urandom_range(0, 1) == 1);
        cycle_end();
      end
      start_pulse(e0);
      run_policy(5, "random");
    end
    idle_cycles(4);

    chk("final_num_q_empty", exp_num_q.size(), 0);
    chk("final_done_q_empty", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", edge_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addr_serial_seq.md
ADDR_SERIAL_SEQ -- requirements
Module: addr_serial_seq

Interface
REQ-001 Parameter ADDR_SERIAL_NUM_WIDTH, default 7, width of the serial number driving addr_sel.
REQ-002 Parameter LAST_NUM, default 126, final serial number of a sequence; SHALL satisfy LAST_NUM < 2**ADDR_SERIAL_NUM_WIDTH.
REQ-003 Parameter DRAIN_CYCLES, default 2, cycles waited after the last number for SRAM read data to settle; SHALL be >= 1.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin a sequence, sampled on rising edge.
REQ-007 stall  input  1  hold current serial number (downstream back-pressure).
REQ-008 abort  input  1  terminate sequence immediately, no done.
REQ-009 addr_serial_num  output  ADDR_SERIAL_NUM_WIDTH  serial number to addr_sel.
REQ-010 valid  output  1  addr_serial_num is issued this cycle.
REQ-011 busy  output  1  sequence in progress (RUN or DRAIN).
REQ-012 done  output  1  one-cycle pulse marking sequence completion.

Function
REQ-013 States SHALL be IDLE, RUN, DRAIN; state, addr_serial_num, drain counter and done are registers.
REQ-014 IDLE: start=1 and abort=0 at an edge -> RUN, addr_serial_num=0.
REQ-015 RUN: stall=0 and addr_serial_num<LAST_NUM at an edge -> addr_serial_num+1.
REQ-016 RUN: stall=0 and addr_serial_num==LAST_NUM at an edge -> DRAIN, drain counter=DRAIN_CYCLES-1, addr_serial_num held.
REQ-017 RUN: stall=1 -> addr_serial_num and state held, no limit on stall length.
REQ-018 DRAIN: counter decrements each edge; at counter==0 edge -> IDLE, addr_serial_num=0, done=1 for exactly that next cycle.
REQ-019 valid SHALL equal (state==RUN) AND NOT stall, combinational from stall only.
REQ-020 busy SHALL equal (state==RUN or state==DRAIN), decoded from registered state.
REQ-021 start while busy=1 SHALL be ignored, no queuing.
REQ-022 abort=1 at an edge in RUN or DRAIN -> IDLE, addr_serial_num=0, done stays 0; abort wins over stall and start.
REQ-023 start accepted in the IDLE cycle where done=1 (back-to-back runs, zero gap).
REQ-024 Nominal latency: start sampled at edge E0; numbers 0..LAST_NUM valid after E0..E(LAST_NUM); DRAIN after E(LAST_NUM+1)..; done=1 after edge E(LAST_NUM+1+DRAIN_CYCLES) (E129 with defaults).
REQ-025 addr_serial_num SHALL never exceed LAST_NUM and SHALL never wrap.

Reset
REQ-026 rst_n=0 SHALL force immediately, independent of clk: state=IDLE, addr_serial_num=0, drain counter=0, done=0, hence valid=0, busy=0.
REQ-027 Reset asserted mid-RUN or mid-DRAIN SHALL discard the sequence with no done pulse; start required after release.
REQ-028 First edge after rst_n deassertion SHALL behave as an ordinary IDLE edge.

Structure
REQ-029 Shared package tpu_pkg SHALL hold ADDR_SERIAL_NUM_WIDTH=7, SRAM_ADDR_WIDTH=10, default LAST_NUM=126 and the state enumeration type.
REQ-030 No sub-module; FSM, serial counter and drain counter SHALL live in addr_serial_seq, whose addr_serial_num connects directly to addr_sel.

Verification
REQ-031 Nominal: start pulse, stall=0 -> addr_serial_num 0,1,...,126 with valid=1 on 127 consecutive cycles; busy=1 for 129 cycles; done=1 exactly one cycle after edge E129.
REQ-032 Stall: assert stall for 5 cycles when addr_serial_num=31 -> value holds 31, valid=0 during stall, resumes at 32, done 5 cycles later (after E134).
REQ-033 Abort: abort at addr_serial_num=62 -> next cycle IDLE, addr_serial_num=0, busy=0, done never asserts; following start gives full 0..126 run.
REQ-034 Reset mid-run: rst_n=0 at addr_serial_num=98 -> outputs 0 before next clk edge; no done after release without start.
REQ-035 Start while busy: extra start pulses at numbers 10 and DRAIN -> sequence unchanged, single done.
REQ-036 Back-to-back: start held in done cycle -> new run begins, addr_serial_num=0 valid next cycle, two done pulses 130 cycles apart.
